// File: rtl/bb_agc_pkg.sv
// bb_agc_pkg: shared constants and helpers for the baseband AGC.
// Contents: register addresses, register reset defaults, Q4.12 gain
// constants, the gain-update kind enum and the output round/saturate helper.
package bb_agc_pkg;

  // Write-side register addresses
  localparam logic [1:0] ADDR_THR  = 2'd0;
  localparam logic [1:0] ADDR_GMAX = 2'd1;
  localparam logic [1:0] ADDR_HANG = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Read-side status addresses
  localparam logic [1:0] RD_GAIN = 2'd0;
  localparam logic [1:0] RD_PEAK = 2'd1;

  // Register reset defaults
  localparam logic [15:0] THR_RST  = 16'h4000;
  localparam logic [15:0] GMAX_RST = 16'h8000;
  localparam logic [15:0] HANG_RST = 16'd1024;
  localparam logic [3:0]  DSH_RST  = 4'd8;
  localparam logic [3:0]  ASH_RST  = 4'd4;

  // Q4.12 gain constants
  localparam logic [15:0] GAIN_UNITY = 16'h1000;
  localparam logic [15:0] AGC_GMIN   = 16'h0010;

  // What the automatic loop does with the gain for one magnitude sample
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_ATTACK,
    UPD_HOLD,
    UPD_DECAY
  } upd_e;

  // Round a Q4.12-scaled product back to sample units (add half, shift 14)
  // and clamp to the signed 16-bit output range.
  function automatic logic [15:0] round_sat16(input logic signed [33:0] p);
    logic signed [33:0] t;
    t = (p + 34'sd8192) >>> 14;
    if (t > 34'sd32767)
      round_sat16 = 16'h7FFF;
    else if (t < -34'sd32768)
      round_sat16 = 16'h8000;
    else
      round_sat16 = t[15:0];
  endfunction

endpackage

// File: rtl/bb_agc_mag.sv
// bb_agc_mag: registered magnitude estimator for the AGC loop.
// mag = max(|x|,|y|) + min(|x|,|y|)/2, with |-32768| taken as 32767 and the
// sum clamped to 16'hFFFF. One cycle latency.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_x, i_y       signed 16-bit samples (two's complement)
//   i_v            input valid
//   o_mag          unsigned 16-bit magnitude estimate
//   o_v            output valid
module bb_agc_mag (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_v,
  output logic [15:0] o_mag,
  output logic        o_v
);

  logic [15:0] w_ax;
  logic [15:0] w_ay;
  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic [16:0] w_sum;

  // The most negative value has no positive twin, so it saturates to 32767
  assign w_ax = (i_x == 16'h8000) ? 16'h7FFF : (i_x[15] ? (~i_x + 16'd1) : i_x);
  assign w_ay = (i_y == 16'h8000) ? 16'h7FFF : (i_y[15] ? (~i_y + 16'd1) : i_y);

  assign w_hi  = (w_ax >= w_ay) ? w_ax : w_ay;
  assign w_lo  = (w_ax >= w_ay) ? w_ay : w_ax;
  assign w_sum = {1'b0, w_hi} + 17'(w_lo >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mag <= '0;
      o_v   <= 1'b0;
    end else begin
      o_v <= i_v;
      if (i_v)
        o_mag <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

endmodule

// File: rtl/bb_agc.sv
// bb_agc: receive-path baseband automatic gain control.
// Scales 18-bit complex samples by a Q4.12 gain into 16-bit outputs through a
// 3-stage pipeline, then adapts the gain from the output magnitude with fast
// attack, hang and slow decay.
// Optional build macro: BB_AGC_PEAKHOLD_EN adds a read-to-clear peak register.
// Ports:
//   mclk, mrst          master clock, asynchronous active-low reset
//   iocs/ioaddr/din     module select, register address, write data
//   iowr, iord          write and read strobes
//   dout                status read data, combinational from ioaddr
//   dix, diy, iv        signed 18-bit input sample and valid strobe
//   dox, doy, ov        signed 16-bit scaled output and valid strobe
module bb_agc #(
  parameter logic [15:0] GMIN = bb_agc_pkg::AGC_GMIN,
  parameter int          OUTW = 16
) (
  input  logic            mclk,
  input  logic            mrst,
  input  logic            iocs,
  input  logic [1:0]      ioaddr,
  input  logic [15:0]     din,
  input  logic            iowr,
  input  logic            iord,
  output logic [15:0]     dout,
  input  logic [17:0]     dix,
  input  logic [17:0]     diy,
  input  logic            iv,
  output logic [OUTW-1:0] dox,
  output logic [OUTW-1:0] doy,
  output logic            ov
);

  import bb_agc_pkg::*;

  logic [15:0] r_thr, r_gmax, r_hang, r_g, r_hc;
  logic        r_man;
  logic [3:0]  r_dsh, r_ash;

  logic [17:0]        r_s1x, r_s1y;
  logic               r_s1v;
  logic signed [33:0] r_px, r_py;
  logic               r_s2v;

  logic        w_wr, w_rd;
  logic [15:0] w_mag;
  logic        w_magv;
  logic [15:0] w_pkrd;
  logic signed [33:0] w_px, w_py;
  logic [15:0] w_gsub, w_gatt, w_ginc, w_gdec;
  logic [16:0] w_gsum;
  upd_e        w_upd;

  assign w_wr = iocs & iowr;
  assign w_rd = iocs & iord;

  // Configuration registers
  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      r_thr  <= THR_RST;
      r_gmax <= GMAX_RST;
      r_hang <= HANG_RST;
      r_man  <= 1'b0;
      r_dsh  <= DSH_RST;
      r_ash  <= ASH_RST;
    end else if (w_wr) begin
      case (ioaddr)
        ADDR_THR:  r_thr  <= din;
        ADDR_GMAX: r_gmax <= din;
        ADDR_HANG: r_hang <= din;
        default: begin
          r_man <= din[15];
          r_dsh <= din[11:8];
          r_ash <= din[3:0];
        end
      endcase
    end
  end

  // Sign-extend the sample and zero-extend the unsigned gain to 34 bits so the
  // product is exact at full width.
  assign w_px = $signed({{16{r_s1x[17]}}, r_s1x}) * $signed({18'd0, r_g});
  assign w_py = $signed({{16{r_s1y[17]}}, r_s1y}) * $signed({18'd0, r_g});

  // Sample pipeline: latch, multiply, round/saturate
  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      r_s1x <= '0;
      r_s1y <= '0;
      r_s1v <= 1'b0;
      r_px  <= '0;
      r_py  <= '0;
      r_s2v <= 1'b0;
      dox   <= '0;
      doy   <= '0;
      ov    <= 1'b0;
    end else begin
      r_s1v <= iv;
      if (iv) begin
        r_s1x <= dix;
        r_s1y <= diy;
      end
      r_s2v <= r_s1v;
      if (r_s1v) begin
        r_px <= w_px;
        r_py <= w_py;
      end
      ov <= r_s2v;
      if (r_s2v) begin
        dox <= round_sat16(r_px);
        doy <= round_sat16(r_py);
      end
    end
  end

  bb_agc_mag u_mag (
    .clk   (mclk),
    .rst_n (mrst),
    .i_x   (dox),
    .i_y   (doy),
    .i_v   (ov),
    .o_mag (w_mag),
    .o_v   (w_magv)
  );

  // Decide the gain action for this magnitude sample
  always_comb begin
    w_upd = UPD_NONE;
    if (!r_man && w_magv) begin
      if (w_mag > r_thr)
        w_upd = UPD_ATTACK;
      else if (r_hc != 16'd0)
        w_upd = UPD_HOLD;
      else
        w_upd = UPD_DECAY;
    end
  end

  // With ash = 0 the subtraction reaches zero, which the floor turns into GMIN.
  assign w_gsub = r_g - (r_g >> r_ash);
  assign w_gatt = (w_gsub < GMIN) ? GMIN : w_gsub;
  // dsh of 15 would still leave bit 15 in the increment; it is meant as +1 only
  assign w_ginc = (r_dsh >= 4'd15) ? 16'd0 : (r_g >> r_dsh);
  assign w_gsum = {1'b0, r_g} + {1'b0, w_ginc} + 17'd1;
  assign w_gdec = (w_gsum > {1'b0, r_gmax}) ? r_gmax : w_gsum[15:0];

  // Gain and hang counter. Leaving manual mode restarts the hang window.
  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      r_g  <= GAIN_UNITY;
      r_hc <= '0;
    end else begin
      if (r_man) begin
        r_g <= r_gmax;
      end else begin
        case (w_upd)
          UPD_ATTACK: begin
            r_g  <= w_gatt;
            r_hc <= r_hang;
          end
          UPD_HOLD:  r_hc <= r_hc - 16'd1;
          UPD_DECAY: r_g  <= w_gdec;
          default: ;
        endcase
      end
      if (w_wr && (ioaddr == ADDR_CTRL) && r_man && !din[15])
        r_hc <= r_hang;
    end
  end

`ifdef BB_AGC_PEAKHOLD_EN
  logic [15:0] r_pk;
  logic        w_pkclr;

  assign w_pkclr = w_rd && (ioaddr == RD_PEAK);

  // A magnitude landing on the read-clear cycle starts the new peak window
  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst)
      r_pk <= '0;
    else if (w_magv)
      r_pk <= (w_pkclr || (w_mag > r_pk)) ? w_mag : r_pk;
    else if (w_pkclr)
      r_pk <= '0;
  end

  assign w_pkrd = r_pk;
`else
  assign w_pkrd = 16'h0000;
`endif

  always_comb begin
    dout = 16'h0000;
    case (ioaddr)
      RD_GAIN: dout = r_g;
      RD_PEAK: dout = w_pkrd;
      default: dout = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_bb_agc.sv
// tb_bb_agc: self-checking bench for bb_agc.
// A behavioural model of the gain loop (integer arithmetic on the gain,
// threshold and hang rules) predicts every output sample and gain value.
// Honours BB_AGC_PEAKHOLD_EN for the peak-register checks.
module tb_bb_agc;

  logic        mclk = 1'b0;
  logic        mrst = 1'b0;
  logic        iocs = 1'b0;
  logic [1:0]  ioaddr = 2'd0;
  logic [15:0] din = 16'h0000;
  logic        iowr = 1'b0;
  logic        iord = 1'b0;
  logic [15:0] dout;
  logic [17:0] dix = 18'h0;
  logic [17:0] diy = 18'h0;
  logic        iv = 1'b0;
  logic [15:0] dox;
  logic [15:0] doy;
  logic        ov;

  int nCmp  = 0;
  int nFail = 0;

  // Reference model state
  int gM, thrM, gmaxM, hangM, manM, dshM, ashM, hcM;

  always #5 mclk = ~mclk;

  bb_agc dut (
    .mclk   (mclk),
    .mrst   (mrst),
    .iocs   (iocs),
    .ioaddr (ioaddr),
    .din    (din),
    .iowr   (iowr),
    .iord   (iord),
    .dout   (dout),
    .dix    (dix),
    .diy    (diy),
    .iv     (iv),
    .dox    (dox),
    .doy    (doy),
    .ov     (ov)
  );

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    gM = 4096; thrM = 16384; gmaxM = 32768; hangM = 1024;
    manM = 0; dshM = 8; ashM = 4; hcM = 0;
  endtask

  // Output = round(x * g / 2^14), clamped to the signed 16-bit range
  function automatic int scaleRef(input int x, input int g);
    longint p, q;
    p = longint'(x) * longint'(g);
    q = (p + 64'sd8192) >>> 14;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int absSat(input int v);
    if (v < -32767) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int magRef(input int ox, input int oy);
    int a, b, m;
    a = absSat(ox);
    b = absSat(oy);
    m = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
    return (m > 65535) ? 65535 : m;
  endfunction

  task automatic modelUpdate(input int mag);
    int inc;
    if (manM != 0) return;
    if (mag > thrM) begin
      gM = gM - gM / (1 << ashM);
      if (gM < 16) gM = 16;
      hcM = hangM;
    end else if (hcM > 0) begin
      hcM--;
    end else begin
      inc = (dshM >= 15) ? 0 : gM / (1 << dshM);
      gM = gM + inc + 1;
      if (gM > gmaxM) gM = gmaxM;
    end
  endtask

  task automatic writeReg(input int addr, input int data);
    iocs = 1'b1; iowr = 1'b1; ioaddr = addr[1:0]; din = data[15:0];
    step();
    iocs = 1'b0; iowr = 1'b0;
    case (addr)
      0: thrM = data;
      1: gmaxM = data;
      2: hangM = data;
      default: begin
        if (manM != 0 && data[15] == 1'b0) hcM = hangM;
        manM = data[15] ? 1 : 0;
        dshM = (data >> 8) & 15;
        ashM = data & 15;
      end
    endcase
    if (manM != 0) gM = gmaxM;
    step();
  endtask

  task automatic readReg(input int addr, output logic [15:0] val);
    iocs = 1'b1; iord = 1'b1; ioaddr = addr[1:0];
    #1;
    val = dout;
    step();
    iocs = 1'b0; iord = 1'b0;
  endtask

  // One isolated sample: latency, output values, single-cycle ov, resulting gain
  task automatic applyStimulus(input int x, input int y);
    logic [15:0] gRd;
    int k, ex, ey;
    ex = scaleRef(x, gM);
    ey = scaleRef(y, gM);
    dix = 18'(x); diy = 18'(y); iv = 1'b1;
    step();
    iv = 1'b0;
    k = 0;
    while (ov !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    checkOutput("ovLatency", k, 2);
    checkOutput("doxSample", {16'h0, dox}, ex & 32'hFFFF);
    checkOutput("doySample", {16'h0, doy}, ey & 32'hFFFF);
    modelUpdate(magRef(ex, ey));
    step();
    checkOutput("ovSinglePulse", {31'b0, ov}, 0);
    step(); step(); step();
    readReg(0, gRd);
    checkOutput("gainAfterSample", {16'h0, gRd}, gM);
  endtask

  function automatic int randIn();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  initial begin
    logic [15:0] rd;
    int qx[$];
    int qy[$];
    int x, y, ovSeen, nB2B;

    // Reset state
    modelReset();
    step(); step();
    checkOutput("rstOv",  {31'b0, ov}, 0);
    checkOutput("rstDox", {16'h0, dox}, 0);
    checkOutput("rstDoy", {16'h0, doy}, 0);
    ioaddr = 2'd0; #1;
    checkOutput("rstGain", {16'h0, dout}, 32'h1000);
    ioaddr = 2'd1; #1;
    checkOutput("rstPeak", {16'h0, dout}, 0);
    ioaddr = 2'd2; #1;
    checkOutput("rstAddr2", {16'h0, dout}, 0);
    mrst = 1'b1;
    step();

    // Unity gain, manual mode
    writeReg(3, 16'h8804);
    writeReg(1, 16'h1000);
    applyStimulus(16384, -16384);
    checkOutput("unityDox", {16'h0, dox}, 32'h1000);
    checkOutput("unityDoy", {16'h0, doy}, 32'hF000);

    // Saturation at maximum manual gain
    writeReg(1, 16'h8000);
    applyStimulus(131071, -131072);
    checkOutput("satDox", {16'h0, dox}, 32'h7FFF);
    checkOutput("satDoy", {16'h0, doy}, 32'h8000);
    readReg(0, rd);
    checkOutput("satGain", {16'h0, rd}, 32'h8000);

    // Back-to-back random samples at a random manual gain
    writeReg(1, int'($urandom_range(16'h0400, 16'h3000)));
    nB2B = 24;
    ovSeen = 0;
    for (int c = 0; c < nB2B + 6; c++) begin
      if (ov === 1'b1) begin
        ovSeen++;
        if (qx.size() > 0) begin
          checkOutput("b2bDox", {16'h0, dox}, qx.pop_front() & 32'hFFFF);
          checkOutput("b2bDoy", {16'h0, doy}, qy.pop_front() & 32'hFFFF);
        end
      end
      if (c < nB2B) begin
        x = randIn(); y = randIn();
        qx.push_back(scaleRef(x, gM));
        qy.push_back(scaleRef(y, gM));
        dix = 18'(x); diy = 18'(y); iv = 1'b1;
      end else begin
        iv = 1'b0;
      end
      step();
    end
    checkOutput("b2bOvCount", ovSeen, nB2B);

    // Attack from unity in auto mode
    writeReg(1, 16'h1000);
    writeReg(0, 16'h1000);
    writeReg(2, 4);
    writeReg(3, 16'h0804);
    applyStimulus(65536, 0);
    readReg(0, rd);
    checkOutput("attack1", {16'h0, rd}, 32'h0F00);
    applyStimulus(65536, 0);
    readReg(0, rd);
    checkOutput("attack2", {16'h0, rd}, 32'h0E10);

    // Drive the gain onto its floor
    writeReg(0, 0);
    writeReg(3, 16'h0801);
    for (int i = 0; i < 12; i++) begin
      x = 65536 + int'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) x = -x;
      applyStimulus(x, randIn());
    end
    readReg(0, rd);
    checkOutput("gminFloor", {16'h0, rd}, 32'h0010);

    // Hang for four samples, then decay
    writeReg(0, 16'h1000);
    writeReg(3, 16'h0804);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(randIn(), randIn());
      if (i == 3) begin
        readReg(0, rd);
        checkOutput("hangHold", {16'h0, rd}, 32'h0010);
      end
    end
    readReg(0, rd);
    checkOutput("decaySteps", {16'h0, rd}, 32'h0012);

    // Fast decay up to the gmax cap
    writeReg(2, 0);
    writeReg(3, 16'h0004);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0);
    readReg(0, rd);
    checkOutput("decayCap", {16'h0, rd}, 32'h1000);

    // dsh of 15 gives +1 steps
    writeReg(1, 16'h2000);
    writeReg(3, 16'h0F04);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    readReg(0, rd);
    checkOutput("dsh15Step", {16'h0, rd}, 32'h1002);

    // Lowering gmax below g waits for the next decay step
    writeReg(1, 16'h0800);
    readReg(0, rd);
    checkOutput("gmaxNoClamp", {16'h0, rd}, 32'h1002);
    applyStimulus(0, 0);
    readReg(0, rd);
    checkOutput("gmaxAtDecay", {16'h0, rd}, 32'h0800);

    // Peak register
    writeReg(3, 16'h8804);
    writeReg(1, 16'h1000);
`ifdef BB_AGC_PEAKHOLD_EN
    readReg(1, rd);
    applyStimulus(8192, 0);
    applyStimulus(4096, 0);
    readReg(1, rd);
    checkOutput("peakHold", {16'h0, rd}, 32'h0800);
    readReg(1, rd);
    checkOutput("peakCleared", {16'h0, rd}, 0);
    dix = 18'h00800; diy = 18'h0; iv = 1'b1;
    step();
    iv = 1'b0;
    step(); step(); step();
    iocs = 1'b1; iord = 1'b1; ioaddr = 2'd1;
    step();
    iocs = 1'b0; iord = 1'b0;
    readReg(1, rd);
    checkOutput("peakClearRace", {16'h0, rd}, 32'h0200);
`else
    applyStimulus(8192, 0);
    readReg(1, rd);
    checkOutput("peakAbsent", {16'h0, rd}, 0);
`endif

    // Reset with two samples in flight
    dix = 18'(randIn()); diy = 18'(randIn()); iv = 1'b1;
    step();
    dix = 18'(randIn()); diy = 18'(randIn());
    step();
    iv = 1'b0;
    mrst = 1'b0;
    ovSeen = 0;
    for (int i = 0; i < 4; i++) begin
      if (ov !== 1'b0) ovSeen++;
      step();
    end
    mrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ov !== 1'b0) ovSeen++;
      step();
    end
    modelReset();
    checkOutput("rstMidOv", ovSeen, 0);
    checkOutput("rstMidDox", {16'h0, dox}, 0);
    checkOutput("rstMidDoy", {16'h0, doy}, 0);
    readReg(0, rd);
    checkOutput("rstMidGain", {16'h0, rd}, 32'h1000);
    // Output 0x3000 sits under the default threshold, so a decay step shows thr reset
    applyStimulus(49152, 0);
    readReg(0, rd);
    checkOutput("rstMidThr", {16'h0, rd}, 32'h1011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
